sal_bank_timer: RTL and testbench

- Per-bank timing tracker. Sits directly downstream of the timing-parameter source and consumes its TIMING_IF (`*_m1` values, i.e. parameter minus 1).
- Watches commands the scheduler issues to one bank. Reports, zero-cycle, which command types are timing-legal next cycle, plus open/closed row state.
- One instance per bank inside the bank controller.

---
 rtl/sal_pkg.sv | 23 ++
 rtl/timing_if.sv | 12 +
 rtl/sal_tcnt.sv | 28 ++
 rtl/sal_bank_timer.sv | 137 +++++++++++++
 tb/tb_sal_bank_timer.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/sal_pkg.sv
// rtl/sal_pkg.sv - shared types for the per-bank timing tracker
package sal_pkg;

  localparam int SAL_CNT_W = 10;

  typedef enum logic [2:0] {
    BANK_CLOSED,
    BANK_OPENING,
    BANK_OPEN,
    BANK_CLOSING,
    BANK_REFRESHING
  } sal_bank_state_t;

  // One bit per command strobe the scheduler can issue to a bank.
  typedef struct packed {
    logic act;
    logic rd;
    logic wr;
    logic pre;
    logic rfsh;
  } sal_cmd_t;

endpackage

// File: rtl/timing_if.sv
// rtl/timing_if.sv - timing parameters (value minus one) from the timing-parameter source
interface TIMING_IF #(parameter int TW = 8);
  logic [TW-1:0] t_rcd_m1;
  logic [TW-1:0] t_ras_m1;
  logic [TW-1:0] t_rp_m1;
  logic [TW-1:0] t_rtp_m1;
  logic [TW-1:0] t_wtp_m1;
  logic [TW-1:0] t_rfc_m1;

  modport SRC (output t_rcd_m1, t_ras_m1, t_rp_m1, t_rtp_m1, t_wtp_m1, t_rfc_m1);
  modport DST (input  t_rcd_m1, t_ras_m1, t_rp_m1, t_rtp_m1, t_wtp_m1, t_rfc_m1);
endinterface

// File: rtl/sal_tcnt.sv
// rtl/sal_tcnt.sv - loadable down-counter that saturates at zero
module sal_tcnt import sal_pkg::*; #(
  parameter int CNT_W = SAL_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] value,
  output logic             is_zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign value   = cnt;
  assign is_zero = (cnt == '0);

endmodule

// File: rtl/sal_bank_timer.sv
// rtl/sal_bank_timer.sv - per-bank command legality tracker with open/closed row state
module sal_bank_timer import sal_pkg::*; #(
  parameter int ROW_W = 16,
  parameter int CNT_W = SAL_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  TIMING_IF.DST            timing_if,
  input  logic             act_i,
  input  logic             rd_i,
  input  logic             wr_i,
  input  logic             pre_i,
  input  logic             ref_i,
  input  logic [ROW_W-1:0] row_i,
  output logic             act_ok_o,
  output logic             rd_ok_o,
  output logic             wr_ok_o,
  output logic             pre_ok_o,
  output logic             ref_ok_o,
  output logic             bank_open_o,
  output logic [ROW_W-1:0] open_row_o,
  output logic             err_o
);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam int C_RCD = 0;
  localparam int C_RAS = 1;
  localparam int C_RTP = 2;
  localparam int C_WTP = 3;
  localparam int C_RP  = 4;
  localparam int C_RFC = 5;

  sal_bank_state_t state, state_nxt;
  sal_cmd_t        cmd;
  logic            multi;
  logic            act_acc, rd_acc, wr_acc, pre_acc, ref_acc;
  logic            viol;
  logic            act_ok, rw_ok, pre_ok;
  logic            ld       [6];
  cnt_t            ld_val   [6];
  logic            zero     [6];
  cnt_t            cnt_value_unused [6];

  assign cmd   = '{act: act_i, rd: rd_i, wr: wr_i, pre: pre_i, rfsh: ref_i};
  assign multi = ($countones(cmd) > 1);

  for (genvar i = 0; i < 6; i++) begin : g_cnt
    sal_tcnt #(.CNT_W(CNT_W)) u_tcnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (ld[i]),
      .load_val (ld_val[i]),
      .value    (cnt_value_unused[i]),
      .is_zero  (zero[i])
    );
  end

  always_comb begin
    act_ok = (state == BANK_CLOSED)
           | ((state == BANK_CLOSING)    & zero[C_RP])
           | ((state == BANK_REFRESHING) & zero[C_RFC]);
    rw_ok  = (state == BANK_OPEN) | ((state == BANK_OPENING) & zero[C_RCD]);
    pre_ok = rw_ok & zero[C_RAS] & zero[C_RTP] & zero[C_WTP];
  end

  // Any multi-strobe cycle is dropped entirely; only a lone legal strobe is accepted.
  always_comb begin
    act_acc = !multi & cmd.act  & act_ok;
    ref_acc = !multi & cmd.rfsh & act_ok;
    rd_acc  = !multi & cmd.rd   & rw_ok;
    wr_acc  = !multi & cmd.wr   & rw_ok;
    pre_acc = !multi & cmd.pre  & pre_ok;
    viol    = multi
            | (cmd.act  & !act_ok) | (cmd.rfsh & !act_ok)
            | (cmd.rd   & !rw_ok)  | (cmd.wr   & !rw_ok)
            | (cmd.pre  & !pre_ok);
  end

  always_comb begin
    ld[C_RCD]     = act_acc;
    ld_val[C_RCD] = cnt_t'(timing_if.t_rcd_m1);
    ld[C_RAS]     = act_acc;
    ld_val[C_RAS] = cnt_t'(timing_if.t_ras_m1);
    ld[C_RTP]     = act_acc | rd_acc;
    ld_val[C_RTP] = act_acc ? '0 : cnt_t'(timing_if.t_rtp_m1);
    ld[C_WTP]     = act_acc | wr_acc;
    ld_val[C_WTP] = act_acc ? '0 : cnt_t'(timing_if.t_wtp_m1);
    ld[C_RP]      = pre_acc;
    ld_val[C_RP]  = cnt_t'(timing_if.t_rp_m1);
    ld[C_RFC]     = ref_acc;
    ld_val[C_RFC] = cnt_t'(timing_if.t_rfc_m1);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      BANK_CLOSED: begin
        if (act_acc)      state_nxt = BANK_OPENING;
        else if (ref_acc) state_nxt = BANK_REFRESHING;
      end
      BANK_OPENING: begin
        if (pre_acc)           state_nxt = BANK_CLOSING;
        else if (zero[C_RCD])  state_nxt = BANK_OPEN;
      end
      BANK_OPEN: begin
        if (pre_acc) state_nxt = BANK_CLOSING;
      end
      BANK_CLOSING, BANK_REFRESHING: begin
        if (act_acc)      state_nxt = BANK_OPENING;
        else if (ref_acc) state_nxt = BANK_REFRESHING;
        else if (act_ok)  state_nxt = BANK_CLOSED;
      end
      default: state_nxt = BANK_CLOSED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BANK_CLOSED;
      open_row_o <= '0;
      err_o      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (act_acc) open_row_o <= row_i;
      if (viol)    err_o      <= 1'b1;
    end
  end

  assign act_ok_o    = act_ok;
  assign ref_ok_o    = act_ok;
  assign rd_ok_o     = rw_ok;
  assign wr_ok_o     = rw_ok;
  assign pre_ok_o    = pre_ok;
  assign bank_open_o = (state == BANK_OPENING) | (state == BANK_OPEN);

endmodule

// File: tb/tb_sal_bank_timer.sv
// tb/tb_sal_bank_timer.sv - scoreboard bench for sal_bank_timer
module tb_sal_bank_timer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        act, rd, wr, pre, rfsh;
  logic [15:0] row;
  logic        act_ok, rd_ok, wr_ok, pre_ok, ref_ok, bank_open, err;
  logic [15:0] open_row;

  int tests = 0;
  int failed = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    string       name;
    logic [6:0]  flags;
    logic [15:0] row;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  TIMING_IF tif ();

  sal_bank_timer #(.ROW_W(16), .CNT_W(10)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .timing_if   (tif),
    .act_i       (act),
    .rd_i        (rd),
    .wr_i        (wr),
    .pre_i       (pre),
    .ref_i       (rfsh),
    .row_i       (row),
    .act_ok_o    (act_ok),
    .rd_ok_o     (rd_ok),
    .wr_ok_o     (wr_ok),
    .pre_ok_o    (pre_ok),
    .ref_ok_o    (ref_ok),
    .bank_open_o (bank_open),
    .open_row_o  (open_row),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  // Flag vector order: {act_ok, ref_ok, rd_ok, wr_ok, pre_ok, bank_open, err}
  function automatic logic [6:0] f7(input logic a, input logic rw, input logic p,
                                    input logic o, input logic er);
    return {a, a, rw, rw, p, o, er};
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      tests++;
      if (e.cyc != cyc ||
          {act_ok, ref_ok, rd_ok, wr_ok, pre_ok, bank_open, err} != e.flags ||
          open_row != e.row) begin
        failed++;
        $display("FAIL %s cyc=%0d: got flags=%b row=%h, required flags=%b row=%h (cyc %0d)",
                 e.name, cyc, {act_ok, ref_ok, rd_ok, wr_ok, pre_ok, bank_open, err},
                 open_row, e.flags, e.row, e.cyc);
      end
    end
  end

  task automatic push_exp(input logic [6:0] ef, input logic [15:0] er, input string nm);
    exp_t x;
    x.cyc = cyc; x.name = nm; x.flags = ef; x.row = er;
    sb.push_back(x);
  endtask

  task automatic tick(input logic a, input logic r, input logic w, input logic p,
                      input logic f, input logic [15:0] rw_addr,
                      input logic [6:0] ef, input logic [15:0] er, input string nm);
    act = a; rd = r; wr = w; pre = p; rfsh = f; row = rw_addr;
    push_exp(ef, er, nm);
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic do_reset();
    act = 0; rd = 0; wr = 0; pre = 0; rfsh = 0; row = '0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    cyc++;
    rst_n = 1'b1;
  endtask

  // ACT at k=0, optional RD/WR, checked through k=last against the hand-derived pre_ok edge.
  task automatic actseq(input int rd_at, input int wr_at, input int pre_at, input int last,
                        input logic [15:0] r, input string nm);
    for (int k = 0; k <= last; k++)
      tick(k == 0, k == rd_at, k == wr_at, 1'b0, 1'b0, r,
           f7(k == 0, k >= 4, k >= pre_at, k >= 1, 1'b0), (k >= 1) ? r : 16'h0, nm);
  endtask

  // Scenarios 1 and 4; with abort set, reset is asserted mid-cycle at k=25.
  task automatic act_pre_ref(input bit abort);
    actseq(-1, -1, 10, 11, 16'h1234, "s1_act");
    tick(0, 0, 0, 1, 0, 16'h0, f7(0, 1, 1, 1, 0), 16'h1234, "s4_pre");
    for (int k = 13; k <= 15; k++)
      tick(0, 0, 0, 0, 0, 16'h0, f7(0, 0, 0, 0, 0), 16'h1234, "s4_closing");
    tick(0, 0, 0, 0, 1, 16'h0, f7(1, 0, 0, 0, 0), 16'h1234, "s4_ref");
    for (int k = 17; k <= 36; k++) begin
      if (abort && k == 25) begin
        act = 0; rd = 0; wr = 0; pre = 0; rfsh = 0;
        push_exp(f7(1, 0, 0, 0, 0), 16'h0, "s6_async_rst");
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        cyc++;
        rst_n = 1'b1;
        tick(1, 0, 0, 0, 0, 16'hBEEF, f7(1, 0, 0, 0, 0), 16'h0, "s6_act_after_rel");
        tick(0, 0, 0, 0, 0, 16'h0, f7(0, 0, 0, 1, 0), 16'hBEEF, "s6_opening");
        return;
      end
      tick(0, 0, 0, 0, 0, 16'h0, f7(0, 0, 0, 0, 0), 16'h1234, "s4_refreshing");
    end
    tick(0, 0, 0, 0, 0, 16'h0, f7(1, 0, 0, 0, 0), 16'h1234, "s4_rfc_done");
  endtask

  initial begin
    tif.t_rcd_m1 = 8'd3;
    tif.t_ras_m1 = 8'd9;
    tif.t_rp_m1  = 8'd3;
    tif.t_rtp_m1 = 8'd1;
    tif.t_wtp_m1 = 8'd7;
    tif.t_rfc_m1 = 8'd20;

    do_reset();
    act_pre_ref(1'b0);

    do_reset();
    actseq(9, -1, 11, 12, 16'h0042, "s2_rd_rtp");

    do_reset();
    actseq(-1, 5, 13, 14, 16'h0077, "s3_wr_wtp");

    do_reset();
    actseq(-1, -1, 10, 9, 16'h00A0, "s5_open");
    tick(1, 0, 0, 1, 0, 16'h5555, f7(0, 1, 1, 1, 0), 16'h00A0, "s5_act_pre");
    tick(0, 0, 0, 0, 0, 16'h0, f7(0, 1, 1, 1, 1), 16'h00A0, "s5_multi_err");
    tick(0, 0, 0, 0, 0, 16'h0, f7(0, 1, 1, 1, 1), 16'h00A0, "s5_err_hold");

    do_reset();
    tick(0, 1, 0, 0, 0, 16'h0, f7(1, 0, 0, 0, 0), 16'h0, "s5_rd_closed");
    for (int k = 1; k <= 3; k++)
      tick(0, 0, 0, 0, 0, 16'h0, f7(1, 0, 0, 0, 1), 16'h0, "s5_err_sticky");
    do_reset();
    tick(0, 0, 0, 0, 0, 16'h0, f7(1, 0, 0, 0, 0), 16'h0, "s5_err_cleared");

    do_reset();
    act_pre_ref(1'b1);

    @(posedge clk); #1;
    cyc++;
    @(negedge clk);
    if (sb.size() != 0) begin
      tests++;
      failed++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
